// File: rtl/johnson_seq_ctrl.sv
// Johnson ring sequencer with run control.
// A twisted-ring counter of width N steps through 2N phases per revolution.
// A small IDLE/RUN/FINISH controller runs it for a latched number of
// revolutions, or continuously when that number is zero. It supports pausing,
// a graceful stop at the end of a revolution, and recovery from illegal ring
// states. Reset is asynchronous and active-low on 'clear'.

module johnson_seq_ctrl #(
    parameter int N  = 6,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic [PW-1:0] nrev,
    output logic [N-1:0]  q,
    output logic [PW-1:0] phase,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] rev
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // The last ring state of a revolution is a single one in the top bit.
    localparam logic [N-1:0]  LAST_Q = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] ONE_PW = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] TWO_N  = PW'(2 * N);

    state_t        state;
    logic [PW-1:0] nrev_lat;

    logic [N-1:0]  q_step;
    logic [N-1:0]  q_inv;
    logic [N-1:0]  q_plus;
    logic [N-1:0]  q_inv_plus;
    logic          q_legal;
    logic          at_boundary;
    logic [PW-1:0] rev_inc;
    logic [PW-1:0] ones;

    // Next ring value: shift left and feed back the inverted top bit.
    assign q_step = {q[N-2:0], ~q[N-1]};

    // A legal state is either a run of ones from bit 0 (q & (q+1) == 0)
    // or a run of ones from bit N-1 (the same test on the complement).
    assign q_inv      = ~q;
    assign q_plus     = q + ONE_N;
    assign q_inv_plus = q_inv + ONE_N;
    assign q_legal    = ((q & q_plus) == '0) || ((q_inv & q_inv_plus) == '0);

    // A revolution completes on the advancing edge that leaves 100..0.
    assign at_boundary = (q == LAST_Q) && !pause;
    assign rev_inc     = rev + ONE_PW;

    // Count the ones in the ring and turn that count into a phase number.
    // In the first half the ring fills from bit 0. In the second half it
    // drains, so the phase is 2N minus the remaining ones.
    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + {{(PW-1){1'b0}}, q[i]};
        end
        phase = q[N-1] ? (TWO_N - ones) : ones;
    end

    // Controller and ring. Any illegal ring state wins: the ring is cleared
    // and err pulses, while state and rev are left untouched.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            q        <= '0;
            rev      <= '0;
            nrev_lat <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (!q_legal) begin
                q   <= '0;
                err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        q <= '0;
                        if (start) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            nrev_lat <= nrev;
                            rev      <= '0;
                        end
                    end
                    RUN: begin
                        if (!pause) begin
                            q <= q_step;
                        end
                        if (at_boundary) begin
                            rev <= rev_inc;
                            if (stop || ((nrev_lat != '0) && (rev_inc == nrev_lat))) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (stop) begin
                            state <= FINISH;
                        end
                    end
                    FINISH: begin
                        if (!pause) begin
                            q <= q_step;
                        end
                        if (at_boundary) begin
                            rev   <= rev_inc;
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        q     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed testbench for johnson_seq_ctrl (N=6, PW=4).
// Expected values are hand-computed from the ring sequence and the run rules.

module tb_johnson_seq_ctrl;

    logic       clk;
    logic       clear;
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] nrev;
    logic [5:0] q;
    logic [3:0] phase;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] rev;
    logic       clk_run;

    int checks;
    int errors;

    logic [5:0] ring [0:11] = '{6'b000000, 6'b000001, 6'b000011, 6'b000111,
                                6'b001111, 6'b011111, 6'b111111, 6'b111110,
                                6'b111100, 6'b111000, 6'b110000, 6'b100000};

    johnson_seq_ctrl #(.N(6), .PW(4)) dut (
        .clk   (clk),
        .clear (clear),
        .start (start),
        .stop  (stop),
        .pause (pause),
        .nrev  (nrev),
        .q     (q),
        .phase (phase),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .rev   (rev)
    );

    // Free-running clock that can be halted in its low phase.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clk_run = 1'b1;
        clear   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        nrev    = 4'd0;

        // Reset values
        #1;
        check_output("rst_q", q, 6'b000000);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_err", err, 1'b0);
        check_output("rst_rev", rev, 4'd0);
        check_output("rst_phase", phase, 4'd0);
        #11;
        clear = 1'b1;
        @(negedge clk);

        // Single revolution: walk all 12 phases, done on the 13th edge
        $display("[TB] single revolution");
        nrev  = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("r1_busy", busy, 1'b1);
        check_output("r1_q0", q, 6'b000000);
        for (int k = 1; k < 12; k++) begin
            tick();
            check_output($sformatf("r1_q%0d", k), q, ring[k]);
            check_output($sformatf("r1_phase%0d", k), phase, k);
            check_output($sformatf("r1_done%0d", k), done, 1'b0);
        end
        tick();
        check_output("r1_done", done, 1'b1);
        check_output("r1_busy_end", busy, 1'b0);
        check_output("r1_rev", rev, 4'd1);
        check_output("r1_q_end", q, 6'b000000);
        tick();
        check_output("r1_done_once", done, 1'b0);
        check_output("r1_idle_q", q, 6'b000000);

        // Three revolutions with a 5-cycle pause at phase 7, start/nrev ignored while busy
        $display("[TB] pause run");
        nrev  = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_ticks(7);
        check_output("p_phase7", phase, 4'd7);
        check_output("p_q7", q, 6'b111110);
        pause = 1'b1;
        start = 1'b1;
        nrev  = 4'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_output($sformatf("p_frozen%0d", k), q, 6'b111110);
        end
        pause = 1'b0;
        start = 1'b0;
        run_ticks(28);
        check_output("p_rev2", rev, 4'd2);
        check_output("p_q_last", q, 6'b100000);
        check_output("p_busy", busy, 1'b1);
        check_output("p_nodone", done, 1'b0);
        tick();
        check_output("p_done", done, 1'b1);
        check_output("p_rev3", rev, 4'd3);
        check_output("p_idle", busy, 1'b0);

        // Continuous mode, stop at phase 4 of revolution 2
        $display("[TB] graceful stop");
        nrev  = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_ticks(16);
        check_output("s_rev1", rev, 4'd1);
        check_output("s_phase4", phase, 4'd4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_output("s_phase5", phase, 4'd5);
        check_output("s_busy", busy, 1'b1);
        run_ticks(6);
        check_output("s_phase11", phase, 4'd11);
        check_output("s_nodone", done, 1'b0);
        tick();
        check_output("s_done", done, 1'b1);
        check_output("s_rev2", rev, 4'd2);
        check_output("s_q0", q, 6'b000000);
        check_output("s_idle", busy, 1'b0);
        tick();
        check_output("s_done_once", done, 1'b0);

        // Illegal ring state deposited mid-run
        $display("[TB] illegal state recovery");
        nrev  = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_ticks(3);
        check_output("e_q3", q, 6'b000111);
        @(negedge clk);
        force dut.q = 6'b010100;
        #1;
        release dut.q;
        tick();
        check_output("e_err", err, 1'b1);
        check_output("e_q", q, 6'b000000);
        check_output("e_rev", rev, 4'd0);
        check_output("e_busy", busy, 1'b1);
        tick();
        check_output("e_err_once", err, 1'b0);
        check_output("e_q1", q, 6'b000001);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_output("e_phase2", phase, 4'd2);
        run_ticks(9);
        check_output("e_nodone", done, 1'b0);
        tick();
        check_output("e_done", done, 1'b1);
        check_output("e_rev1", rev, 4'd1);

        // Asynchronous clear with the clock halted
        $display("[TB] async clear");
        nrev  = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_ticks(9);
        check_output("c_phase9", phase, 4'd9);
        @(negedge clk);
        #1;
        clk_run = 1'b0;
        clear   = 1'b0;
        #1;
        check_output("c_q", q, 6'b000000);
        check_output("c_busy", busy, 1'b0);
        check_output("c_rev", rev, 4'd0);
        check_output("c_phase", phase, 4'd0);
        check_output("c_done", done, 1'b0);
        #1;
        clear = 1'b1;
        #4;
        clk_run = 1'b1;
        nrev    = 4'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check_output("c_run_busy", busy, 1'b1);
        check_output("c_run_q", q, 6'b000000);
        run_ticks(11);
        check_output("c_run_phase11", phase, 4'd11);
        tick();
        check_output("c_run_done", done, 1'b1);
        check_output("c_run_rev", rev, 4'd1);

        // Stop coincident with nrev completion, start in the same cycle ignored
        $display("[TB] coincident stop");
        nrev  = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_ticks(23);
        check_output("x_rev1", rev, 4'd1);
        check_output("x_q_last", q, 6'b100000);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        check_output("x_done", done, 1'b1);
        check_output("x_busy", busy, 1'b0);
        check_output("x_rev2", rev, 4'd2);
        check_output("x_q0", q, 6'b000000);
        tick();
        check_output("x_done_once", done, 1'b0);
        check_output("x_still_idle", busy, 1'b0);
        check_output("x_idle_q", q, 6'b000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 Parameter: N, default 6, Johnson ring width; 2N phases per revolution.
REQ-002 Parameter: PW, default 4, phase/count width, equal to clog2(2N).
REQ-003 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-004 Port: clear  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  begin a run; sampled only in IDLE.
REQ-006 Port: stop  input  1  request graceful stop at the end of the current revolution.
REQ-007 Port: pause  input  1  freeze the ring while high in RUN/FINISH.
REQ-008 Port: nrev  input  PW  revolutions per run, latched at start; 0 = continuous.
REQ-009 Port: q  output  N  Johnson ring state.
REQ-010 Port: phase  output  PW  decoded phase 0..2N-1.
REQ-011 Port: busy  output  1  high in RUN or FINISH.
REQ-012 Port: done  output  1  one-cycle pulse on run completion.
REQ-013 Port: err  output  1  one-cycle pulse on illegal ring state detection.
REQ-014 Port: rev  output  PW  completed revolutions in the current run.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FINISH; encoding is free.
REQ-016 Ring step SHALL be q <= {q[N-2:0], ~q[N-1]}: 000000 -> 000001 -> ... -> 111111 -> 111110 -> ... -> 100000 -> 000000.
REQ-017 IDLE: q held at 0, rev held; start=1 -> RUN next edge, nrev latched, rev <= 0, q stays 0 on that edge.
REQ-018 RUN/FINISH: each edge with pause=0 advances q one step; pause=1 holds q, rev and state.
REQ-019 Revolution boundary SHALL be the edge q 100000 -> 000000; rev increments on that edge, wrapping modulo 2^PW in continuous mode.
REQ-020 RUN with latched nrev != 0: on the boundary edge where rev+1 == nrev -> IDLE, done=1 for one cycle, busy=0 on the same edge.
REQ-021 RUN with stop=1 (pause irrelevant) -> FINISH next edge; stop ignored outside RUN.
REQ-022 FINISH: on the next boundary edge -> IDLE with done=1; stop sampled while q=100000 and pause=0 completes on that same edge (single done).
REQ-023 Stop coincident with the nrev-completion boundary SHALL produce exactly one done and enter IDLE.
REQ-024 start while busy SHALL be ignored; nrev changes after latch SHALL have no effect.
REQ-025 phase SHALL be combinational: ones(q) if q[N-1]=0, else 2N - ones(q).
REQ-026 Legal q SHALL be 0^k1^m (ones contiguous from bit 0) or 1^m0^k (ones contiguous from bit N-1).
REQ-027 Illegal q in any state SHALL, on the next edge, force q <= 0 and pulse err; state and rev unchanged; that edge counts as no boundary.
REQ-028 done and err SHALL be registered and never high for two consecutive cycles from one event.

Reset
REQ-029 clear=0 SHALL immediately, without clk, force IDLE, q=0, rev=0, done=0, err=0, busy=0, latched nrev=0.
REQ-030 clear low mid-run SHALL abort without done; after release, first start behaves as from power-up.
REQ-031 Release of clear SHALL be treated as synchronous to clk by the environment; no internal synchronizer.

Verification
REQ-032 nrev=1, start pulse, no pause -> busy high, q walks 12 legal states, phase 0..11, done pulse on 13th edge after start, rev=1, q=0.
REQ-033 nrev=3, pause high for 5 cycles at phase 7 -> q frozen at 111110 for 5 cycles; done after 36 advancing edges; rev=3.
REQ-034 nrev=0, stop asserted at phase 4 of revolution 2 -> FINISH, completes to 000000, done once, rev=2.
REQ-035 Force q=010100 via bench deposit in RUN -> err pulse, q=000000 next edge, rev unchanged, busy stays high.
REQ-036 clear pulsed low at phase 9 with clk stopped -> outputs at reset values immediately; start after release yields normal run.
REQ-037 nrev=2, stop at q=100000 of revolution 2 -> single done on that edge, start in same cycle ignored.
